wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port between two writeback sources: the ALU result path and the memory-load path. Each source uses a valid/ready handshake. Memory loads have fixed priority, with a starvation guard for the ALU. The block registers the winning write and drives the register-file write port, plus a matching forwarding tap for hazard bypass. It sits between the execute/memory stages and the register file, and replaces the direct mem_to_reg mux selection.

Parameters:
DATA_W, 32, register data width
REG_AW, 5, register address width (32 registers)
STARVE_MAX, 3, consecutive ALU denials after which the ALU wins one arbitration; legal range 1..15

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
wb_enable  in  1  1 = arbitration allowed; 0 = pipeline freeze, no grants
alu_valid  in  1  ALU write request
alu_rd  in  REG_AW  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
mem_valid  in  1  load write request
mem_rd  in  REG_AW  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load request accepted this cycle (combinational)
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  REG_AW  register-file write address (registered)
rf_wdata  out  DATA_W  register-file write data (registered)
fwd_valid  out  1  forwarding tap valid; equals rf_we
fwd_rd  out  REG_AW  equals rf_waddr
fwd_data  out  DATA_W  equals rf_wdata
wb_src  out  2  source of the current rf write: 0 none, 1 ALU, 2 MEM (registered)

Behaviour:
- Reset (rst_n=0, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, wb_src=0, starve_cnt=0. alu_ready and mem_ready are forced to 0 while reset is asserted.
- Handshake: a transfer occurs when valid and ready are both 1 in the same cycle. A source holds valid, rd and data stable until it is accepted. Ready does not depend on ready from any downstream stage.
- Grant logic, combinational, evaluated when wb_enable=1:
  - Only mem_valid: mem_ready=1.
  - Only alu_valid: alu_ready=1.
  - Both valid and starve_cnt<STARVE_MAX: mem_ready=1, alu_ready=0.
  - Both valid and starve_cnt==STARVE_MAX: alu_ready=1, mem_ready=0.
  - At most one ready is high in any cycle.
- wb_enable=0: both ready=0. Next edge: rf_we=0, wb_src=0, starve_cnt holds.
- Latency: a request accepted in cycle N appears on rf_*/fwd_* in cycle N+1 and is valid for exactly one cycle. Throughput is one write per cycle.
- No grant in cycle N: rf_we=0 and wb_src=0 in N+1. rf_waddr and rf_wdata hold their previous values.
- Register x0: a request with rd=0 is accepted normally (ready asserted, counts as a grant) but produces rf_we=0 and wb_src=0 in N+1. The x0 write is suppressed.
- Starvation counter (starve_cnt, 4 bits):
  - Increments when alu_valid=1, alu_ready=0 and wb_enable=1.
  - Clears on any ALU acceptance, or when alu_valid=0.
  - Saturates at STARVE_MAX.
- Simultaneous same-rd requests: only the winner is written that cycle. The loser writes in a later cycle. Program order between sources is the upstream pipeline's responsibility; this block only keeps each source's own accepted writes in order.
- Reset asserted mid-transfer: the in-flight registered write is dropped (rf_we=0 immediately). Sources must re-present their requests after reset.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and REG_AW defaults
  - typedef enum logic [1:0] wb_src_e {WB_NONE=0, WB_ALU=1, WB_MEM=2}
  - typedef struct wb_req_t {rd, data}
- Sub-module wb_starve_counter holds the saturating counter, with ports clk, rst_n, inc, clr and sat (sat asserted when count==STARVE_MAX).
- Grant mux and output register stay in the top level.

Test Plan:
1. Reset: hold rst_n=0 with both valid=1 -> readies=0, rf_we=0, wb_src=0. Release -> mem wins first, rf_we=1 on the following cycle.
2. Single ALU: alu_valid=1, rd=7, data=0xDEADBEEF in cycle 5 -> alu_ready=1 in cycle 5; cycle 6 shows rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF, wb_src=1, fwd_* identical.
3. Contention with STARVE_MAX=3: both valid continuously, mem rd=3/4/5, alu rd=9:
   - Cycles 0-2: mem grants.
   - Cycle 3: ALU grant (rf shows rd=9 in cycle 4).
   - Cycle 4: mem resumes, starve_cnt=0.
4. x0 suppression: mem_valid=1, mem_rd=0, data=0x1234 -> mem_ready=1, next cycle rf_we=0, wb_src=0.
5. Freeze: wb_enable=0 for 2 cycles with both valid -> readies=0, rf_we=0, starve_cnt unchanged. Re-enable -> normal priority resumes.
6. Async reset mid-stream: assert rst_n=0 between clock edges while rf_we=1 -> rf_we falls immediately without waiting for a clock edge, and starve_cnt=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback stage.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_MEM  = 2'd2
   } wb_src_e;

   typedef struct packed {
      logic [WB_REG_AW-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating count of consecutive ALU denials; sat tells the arbiter to let the ALU win once.
module wb_starve_counter #(
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   assign sat = (cnt_q == 4'(STARVE_MAX));

   // Clear wins over increment; the count parks at STARVE_MAX.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the ALU and load writeback paths.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W     = WB_DATA_W,
   parameter int REG_AW     = WB_REG_AW,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_enable,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data,
   output logic [1:0]        wb_src
);

   logic              starveSat;
   logic              starveInc;
   logic              starveClr;
   logic              grant;
   logic [REG_AW-1:0] selRd;
   logic [DATA_W-1:0] selData;

   logic              rf_we_q,    rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   wb_src_e           wb_src_q,   wb_src_d;

   // Loads win by default; a saturated starvation count hands one slot to the ALU.
   assign alu_ready = rst_n & wb_enable & alu_valid & (~mem_valid | starveSat);
   assign mem_ready = rst_n & wb_enable & mem_valid & ~(alu_valid & starveSat);
   assign grant     = alu_ready | mem_ready;

   assign starveInc = wb_enable & alu_valid & ~alu_ready;
   assign starveClr = ~alu_valid | alu_ready;

   wb_starve_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (starveInc),
      .clr   (starveClr),
      .sat   (starveSat)
   );

   assign selRd   = alu_ready ? alu_rd   : mem_rd;
   assign selData = alu_ready ? alu_data : mem_data;

   // Writes to x0 are accepted but never reach the register file.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      wb_src_d   = WB_NONE;
      if (grant && (selRd != '0)) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = selRd;
         rf_wdata_d = selData;
         wb_src_d   = alu_ready ? WB_ALU : WB_MEM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_src_q   <= WB_NONE;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wb_src_q   <= wb_src_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign wb_src    = wb_src_q;
   assign fwd_valid = rf_we_q;
   assign fwd_rd    = rf_waddr_q;
   assign fwd_data  = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a rule-level reference model.
module tb_wb_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SM = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wb_enable = 1'b0;
   logic          alu_valid = 1'b0;
   logic [AW-1:0] alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          alu_ready;
   logic          mem_valid = 1'b0;
   logic [AW-1:0] mem_rd = '0;
   logic [DW-1:0] mem_data = '0;
   logic          mem_ready;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          fwd_valid;
   logic [AW-1:0] fwd_rd;
   logic [DW-1:0] fwd_data;
   logic [1:0]    wb_src;

   int vectors = 0;
   int miscompares = 0;

   int            mStarve;
   logic          mWe;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mData;
   logic [1:0]    mSrc;
   logic          gA, gM;
   logic          oA, oM;

   wb_port_arbiter #(
      .DATA_W     (DW),
      .REG_AW     (AW),
      .STARVE_MAX (SM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_enable (wb_enable),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data),
      .wb_src    (wb_src)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mStarve = 0;
      mWe     = 1'b0;
      mAddr   = '0;
      mData   = '0;
      mSrc    = 2'd0;
   endtask

   task automatic checkRf(input string tag);
      checkOutput({tag, ".rf_we"},     rf_we,     mWe);
      checkOutput({tag, ".wb_src"},    wb_src,    mSrc);
      checkOutput({tag, ".rf_waddr"},  rf_waddr,  mAddr);
      checkOutput({tag, ".rf_wdata"},  rf_wdata,  mData);
      checkOutput({tag, ".fwd_valid"}, fwd_valid, mWe);
      checkOutput({tag, ".fwd_rd"},    fwd_rd,    mAddr);
      checkOutput({tag, ".fwd_data"},  fwd_data,  mData);
   endtask

   // One clock cycle with the currently driven inputs: readies checked mid-cycle, rf after the edge.
   task automatic applyStimulus();
      @(negedge clk);
      gA = 1'b0;
      gM = 1'b0;
      if (wb_enable) begin
         if (alu_valid && mem_valid) begin
            if (mStarve >= SM) gA = 1'b1;
            else               gM = 1'b1;
         end else begin
            gA = alu_valid;
            gM = mem_valid;
         end
      end
      checkOutput("alu_ready", alu_ready, gA);
      checkOutput("mem_ready", mem_ready, gM);
      oA = alu_ready;
      oM = mem_ready;
      @(posedge clk);
      #1;
      if (wb_enable && alu_valid && !gA) mStarve = (mStarve < SM) ? mStarve + 1 : SM;
      else if (!alu_valid || gA)         mStarve = 0;
      mWe  = 1'b0;
      mSrc = 2'd0;
      if (gA && alu_rd != 0) begin
         mWe = 1'b1; mAddr = alu_rd; mData = alu_data; mSrc = 2'd1;
      end else if (gM && mem_rd != 0) begin
         mWe = 1'b1; mAddr = mem_rd; mData = mem_data; mSrc = 2'd2;
      end
      checkRf("cycle");
   endtask

   // Drops reset between edges, checks the immediate effect, and releases away from the edge.
   task automatic doAsyncReset();
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("arst.rf_we", rf_we, 1'b0);
      checkOutput("arst.wb_src", wb_src, 2'd0);
      checkOutput("arst.alu_ready", alu_ready, 1'b0);
      checkOutput("arst.mem_ready", mem_ready, 1'b0);
      checkRf("arst");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] expA;
      logic [3:0] expM;
      logic [4:0] patA;

      // Reset with both sources requesting.
      modelReset();
      wb_enable = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'hA5A5_0001;
      mem_valid = 1'b1; mem_rd = 5'd3;  mem_data = 32'h0000_0300;
      #12;
      checkOutput("reset.alu_ready", alu_ready, 1'b0);
      checkOutput("reset.mem_ready", mem_ready, 1'b0);
      checkRf("reset");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("reset.first_mem", oM, 1'b1);
      checkOutput("reset.first_we", rf_we, 1'b1);

      // Single ALU write.
      alu_valid = 1'b0; mem_valid = 1'b0;
      applyStimulus();
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEAD_BEEF;
      applyStimulus();
      checkOutput("single.alu_ready", oA, 1'b1);
      checkOutput("single.wdata", rf_wdata, 32'hDEAD_BEEF);
      checkOutput("single.waddr", rf_waddr, 5'd7);
      checkOutput("single.src", wb_src, 2'd1);
      alu_valid = 1'b0;
      applyStimulus();
      checkOutput("single.one_cycle", rf_we, 1'b0);

      // Continuous contention: expect M M M A M.
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0900;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h0000_0300;
      patA = 5'b01000;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput($sformatf("contend.alu%0d", i), oA, patA[i]);
         if (oA) checkOutput("contend.alu_rd", rf_waddr, 5'd9);
         if (gM) begin
            mem_rd   = (mem_rd == 5'd5) ? 5'd3 : mem_rd + 5'd1;
            mem_data = mem_data + 32'h100;
         end
      end

      // x0 write accepted but suppressed.
      alu_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234;
      applyStimulus();
      checkOutput("x0.mem_ready", oM, 1'b1);
      checkOutput("x0.rf_we", rf_we, 1'b0);
      mem_valid = 1'b0;
      applyStimulus();

      // Freeze holds the starvation count: M M - - M A.
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0000_0B00;
      mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h0000_0C00;
      expA = 4'b0000; expM = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         wb_enable = (i == 2 || i == 3) ? 1'b0 : 1'b1;
         applyStimulus();
         if (i < 4) begin
            checkOutput($sformatf("freeze.alu%0d", i), oA, expA[i]);
            checkOutput($sformatf("freeze.mem%0d", i), oM, expM[i]);
         end else begin
            checkOutput($sformatf("freeze.alu%0d", i), oA, (i == 5));
         end
      end
      wb_enable = 1'b1;

      // Async reset mid-stream clears the starvation count.
      applyStimulus();
      applyStimulus();
      checkOutput("arst.pre_we", rf_we, 1'b1);
      doAsyncReset();
      patA = 5'b01000;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput($sformatf("post_rst.alu%0d", i), oA, patA[i]);
      end

      // Randomized traffic under the handshake rules.
      for (int n = 0; n < 600; n++) begin
         if (!alu_valid || gA) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data  = $urandom;
         end
         if (!mem_valid || gM) begin
            mem_valid = ($urandom_range(0, 9) < 6);
            mem_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mem_data  = $urandom;
         end
         wb_enable = ($urandom_range(0, 7) != 0);
         applyStimulus();
         if ($urandom_range(0, 99) == 0) begin
            doAsyncReset();
            alu_valid = 1'b0;
            mem_valid = 1'b0;
            gA = 1'b0;
            gM = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
